ws2812_driver: RTL and testbench

- Serial line encoder directly downstream of the image controller.
- Consumes the controller's one-bit colour stream (`datain`) and drives the WS2812 LED-matrix data pin with NRZ pulse-width encoded bits.
- Returns a one-cycle `done` strobe per bit that paces the upstream bit counter.
- After every full frame of bits, inserts the low latch interval the LEDs require before the next frame.

---
 rtl/ws2812_driver.sv | 75 +++++++
 tb/tb_ws2812_driver.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ws2812_driver.sv
// ws2812_driver: NRZ pulse-width encoder for a WS2812 data line with frame latch gap
module ws2812_driver #(
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 63,
  parameter int TLATCH     = 4000,
  parameter int FRAME_BITS = 3072
) (
  input  logic clk,
  input  logic rst_n,
  input  logic datain,
  output logic dout,
  output logic done,
  output logic latching
);
  localparam int CMAX = TLATCH > TBIT ? TLATCH : TBIT;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int BW   = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  typedef enum logic [1:0] {LATCH, HIGH, LOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, thigh, tlow;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic cur, cur_n;
  assign thigh = cur ? CW'(T1H) : CW'(T0H);
  assign tlow  = CW'(TBIT) - thigh;
  // next-state: count out each phase, sample datain only when entering HIGH
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bitcnt_n = bitcnt;
    cur_n    = cur;
    if (state == LATCH) begin
      if (cnt == CW'(TLATCH - 1)) begin
        state_n = HIGH;
        cnt_n   = '0;
        cur_n   = datain;
      end
    end else if (state == HIGH) begin
      if (cnt == thigh - 1'b1) begin
        state_n = LOW;
        cnt_n   = '0;
      end
    end else if (cnt == tlow - 1'b1) begin
      cnt_n = '0;
      if (bitcnt == BW'(FRAME_BITS - 1)) begin
        bitcnt_n = '0;
        state_n  = LATCH;
      end else begin
        bitcnt_n = bitcnt + 1'b1;
        cur_n    = datain;
        state_n  = HIGH;
      end
    end
  end
  // state and outputs registered from next state so dout rises on the sampling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LATCH;
      cnt      <= '0;
      bitcnt   <= '0;
      cur      <= 1'b0;
      dout     <= 1'b0;
      done     <= 1'b0;
      latching <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bitcnt   <= bitcnt_n;
      cur      <= cur_n;
      dout     <= state_n == HIGH;
      done     <= state == HIGH && state_n == LOW;
      latching <= state_n == LATCH;
    end
  end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: scoreboard bench for ws2812_driver pulse widths, strobes and latch gaps
`timescale 1ns/1ps
module tb_ws2812_driver;
  localparam int T0H = 20, T1H = 40, TBIT = 63, TLATCH = 4000, FRAME_BITS = 24;
  logic clk = 1'b0, rst_n = 1'b0, datain = 1'b0;
  logic dout, done, latching;
  int vectors = 0, miscompares = 0;
  int sb[$];
  bit prev_tog = 1'b0;
  int hi_run = 0, low_run = 0, latch_run = 0, last_hi = 0, fbits = 0, exp_hi;
  bit have_last = 1'b0;
  logic prev_dout = 1'b0, prev_done = 1'b0;
  logic [8:0] tv = 9'b101011001;

  ws2812_driver #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH), .FRAME_BITS(FRAME_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .dout(dout), .done(done), .latching(latching)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input bit t);
    int n = 0;
    bit hi = 1'b0;
    @(negedge clk);
    while (!done && n < 6000) begin
      if (dout) hi = 1'b1;
      if (t && hi) datain = ~datain;
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic send(input logic v, input bit t, input bit first);
    if (!first) wait_done(prev_tog);
    if (t) repeat (10) begin @(posedge clk); #1 datain = ~datain; end
    if (!first) repeat (5) @(posedge clk);
    #1 datain = v;
    sb.push_back(v ? T1H : T0H);
    prev_tog = t;
  endtask

  // monitor: measures phases on the line and pops the scoreboard on every done strobe
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0; low_run = 0; latch_run = 0; fbits = 0;
      have_last = 1'b0; prev_dout = 1'b0; prev_done = 1'b0;
    end else begin
      if (dout && !prev_dout) begin
        if (have_last) check("low_width", low_run, TBIT - last_hi);
        if (latch_run > 0) begin
          check("latch_width", latch_run, TLATCH);
          if (have_last) check("frame_bits", fbits, FRAME_BITS);
          fbits = 0;
        end
        hi_run = 0; low_run = 0; latch_run = 0;
      end
      if (dout) hi_run++;
      if (!dout && !latching) low_run++;
      if (latching) latch_run++;
      if (done) begin
        check("done_edge", int'({prev_dout, dout, prev_done}), 3'b100);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got done with no expected bit at %0t", $time);
        end else begin
          exp_hi = sb.pop_front();
          check("high_width", hi_run, exp_hi);
        end
        last_hi = hi_run;
        have_last = 1'b1;
        fbits++;
      end
      prev_dout = dout;
      prev_done = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_done", int'(done), 0);
    check("rst_latching", int'(latching), 1);
    for (int i = 0; i < FRAME_BITS; i++)
      send(i < 3 ? 1'b0 : i < 7 ? 1'b1 : i < 15 ? i[0] : tv[i-15], i >= 15, i == 0);
    if (!rst_n) begin @(posedge clk); #1 rst_n = 1'b1; end
    send(1'b1, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!dout && n < 6000) begin @(negedge clk); n++; end
    if (!dout) check("rise_timeout", 0, 1);
    repeat (10) @(posedge clk);
    check("pre_rst_dout", int'(dout), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_latching", int'(latching), 1);
    sb.delete();
    repeat (3) @(posedge clk);
    for (int i = 0; i < FRAME_BITS; i++) begin
      send((i % 3) == 0, 1'b0, i == 0);
      if (i == 0) begin @(posedge clk); #1 rst_n = 1'b1; end
    end
    send(1'b0, 1'b0, 1'b0);
    wait_done(prev_tog);
    repeat (5) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  end
endmodule
